// File: rtl/vga_pkg.sv
// vga_pkg: shared screen defaults, controller state and fixed-point types
package vga_pkg;
  localparam int SCREEN_W_DEF = 800;
  localparam int SCREEN_H_DEF = 600;
  typedef enum logic [1:0] {IDLE, FLIGHT, REST} proj_state_t;
  typedef logic signed [15:0] vel_t;
  typedef logic signed [13:0] pos_t;
endpackage

// File: rtl/tick_divider.sv
// tick_divider: one-cycle tick every TICK_DIV clocks while clr is low
module tick_divider #(
  parameter int TICK_DIV = 400000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == CW'(TICK_DIV - 1);
  // count up, wrapping on tick, held at zero while cleared
  always_comb cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  // counter register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/projectile_ctl.sv
// projectile_ctl: mouse-tracked sprite launched under gravity with walls, ceiling and lossy floor bounces; PROJECTILE_WIND_EN adds a signed wind input
module projectile_ctl
  import vga_pkg::*;
#(
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int OBJ_W       = 48,
  parameter int OBJ_H       = 64,
  parameter int TICK_DIV    = 400000,
  parameter int FRAC_BITS   = 3,
  parameter int GRAVITY     = 1,
  parameter int DAMP_SHIFT  = 2,
  parameter int MAX_BOUNCES = 4
) (
  input  logic               clk,
  input  logic               rst,
`ifdef PROJECTILE_WIND_EN
  input  logic signed [3:0]  wind,
`endif
  input  logic               launch,
  input  logic               rearm,
  input  logic        [11:0] mouse_xpos,
  input  logic        [11:0] mouse_ypos,
  input  logic signed [15:0] vx_init,
  input  logic signed [15:0] vy_init,
  output logic        [11:0] xpos,
  output logic        [11:0] ypos,
  output logic               busy,
  output logic               landed,
  output logic        [3:0]  bounces
);
  localparam int X_MAX   = SCREEN_W - OBJ_W;
  localparam int FLOOR_Y = SCREEN_H - OBJ_H;
  proj_state_t state_q, state_d;
  pos_t x_q, x_d, y_q, y_d;
  vel_t vx_q, vx_d, vy_q, vy_d, vx_r, vx_w, vy_f, vy_abs;
  logic [3:0] b_q, b_d;
  logic busy_q, busy_d, landed_q, landed_d, tick, hit_x;
  logic signed [17:0] xc, yc;
  tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != FLIGHT),
    .tick (tick)
  );
  // candidate positions, wall-reflected vx and damped floor-rebound vy for this tick
  always_comb begin
    xc = 18'(x_q) + 18'(vx_q >>> FRAC_BITS);
    yc = 18'(y_q) + 18'(vy_q >>> FRAC_BITS);
    hit_x = xc[17] || xc > 18'(X_MAX);
    vx_r = hit_x ? -vx_q : vx_q;
`ifdef PROJECTILE_WIND_EN
    vx_w = vx_r + vel_t'(wind);
`else
    vx_w = vx_r;
`endif
    vy_f = -(vy_q - (vy_q >>> DAMP_SHIFT));
    vy_abs = vy_f[15] ? -vy_f : vy_f;
  end
  // next-state, physics update and registered status outputs
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    vx_d = vx_q;
    vy_d = vy_q;
    b_d = b_q;
    case (state_q)
      IDLE: begin
        x_d = pos_t'({2'b00, mouse_xpos});
        y_d = pos_t'({2'b00, mouse_ypos > 12'(FLOOR_Y) ? 12'(FLOOR_Y) : mouse_ypos});
        if (launch) begin
          state_d = FLIGHT;
          vx_d = vx_init;
          vy_d = vy_init;
          b_d = '0;
        end
      end
      FLIGHT: if (tick) begin
        x_d = xc[17] ? '0 : xc > 18'(X_MAX) ? pos_t'(X_MAX) : xc[13:0];
        vx_d = vx_w;
        if (yc[17]) begin
          y_d = '0;
          vy_d = '0;
        end else if (yc >= 18'(FLOOR_Y)) begin
          y_d = pos_t'(FLOOR_Y);
          b_d = b_q == 4'hf ? b_q : b_q + 4'd1;
          if (5'(b_q) + 5'd1 == 5'(MAX_BOUNCES) || (vy_abs >>> FRAC_BITS) == '0) begin
            vy_d = '0;
            vx_d = '0;
            state_d = REST;
          end else vy_d = vy_f;
        end else begin
          y_d = yc[13:0];
          vy_d = vy_q + vel_t'(GRAVITY);
        end
      end
      REST: state_d = rearm ? IDLE : REST;
      default: state_d = IDLE;
    endcase
    busy_d = state_d == FLIGHT;
    landed_d = state_d == REST && state_q != REST;
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      vx_q <= '0;
      vy_q <= '0;
      b_q <= '0;
      busy_q <= 1'b0;
      landed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      vx_q <= vx_d;
      vy_q <= vy_d;
      b_q <= b_d;
      busy_q <= busy_d;
      landed_q <= landed_d;
    end
  end
  assign xpos = x_q[11:0];
  assign ypos = y_q[11:0];
  assign busy = busy_q;
  assign landed = landed_q;
  assign bounces = b_q;
endmodule

// File: tb/tb_projectile_ctl.sv
// tb_projectile_ctl: scoreboarded random and directed checks against a tick-level physics model
module tb_projectile_ctl;
  localparam int TD = 4;
  localparam int MAXB = 2;
  localparam int XMAX = 752;
  localparam int FLOOR = 536;
  logic clk = 1'b0;
  logic rst = 1'b1, launch = 1'b0, rearm = 1'b0;
  logic [11:0] mouse_xpos = '0, mouse_ypos = '0;
  logic signed [15:0] vx_init = '0, vy_init = '0;
  logic [11:0] xpos, ypos;
  logic busy, landed;
  logic [3:0] bounces;
  int vec = 0, miss = 0, cyc = 0;
  logic [29:0] exp_q[$];
  int m_st = 0, m_x = 0, m_y = 0, m_vx = 0, m_vy = 0, m_cnt = 0, m_b = 0, m_land = 0;
  always #5 clk = ~clk;
  projectile_ctl #(.TICK_DIV(TD), .MAX_BOUNCES(MAXB)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef PROJECTILE_WIND_EN
    .wind       (4'sd0),
`endif
    .launch     (launch),
    .rearm      (rearm),
    .mouse_xpos (mouse_xpos),
    .mouse_ypos (mouse_ypos),
    .vx_init    (vx_init),
    .vy_init    (vy_init),
    .xpos       (xpos),
    .ypos       (ypos),
    .busy       (busy),
    .landed     (landed),
    .bounces    (bounces)
  );
  // reference model: 0 idle, 1 flight, 2 rest; physics applied once per tick in whole pixels/velocity units
  always @(posedge clk) begin
    int xc, yc, v, nvx, prev;
    prev = m_st;
    if (rst) begin
      m_st = 0; m_x = 0; m_y = 0; m_vx = 0; m_vy = 0; m_cnt = 0; m_b = 0;
    end else if (m_st == 0) begin
      m_x = mouse_xpos;
      m_y = mouse_ypos > FLOOR ? FLOOR : mouse_ypos;
      if (launch) begin
        m_st = 1; m_vx = vx_init; m_vy = vy_init; m_cnt = 0; m_b = 0;
      end
    end else if (m_st == 1) begin
      if (m_cnt != TD - 1) m_cnt++;
      else begin
        m_cnt = 0;
        xc = m_x + (m_vx >>> 3);
        yc = m_y + (m_vy >>> 3);
        nvx = m_vx;
        if (xc < 0) begin m_x = 0; nvx = -m_vx; end
        else if (xc > XMAX) begin m_x = XMAX; nvx = -m_vx; end
        else m_x = xc;
        if (yc < 0) begin m_y = 0; m_vy = 0; end
        else if (yc >= FLOOR) begin
          m_y = FLOOR;
          v = -(m_vy - (m_vy >>> 2));
          if (m_b + 1 == MAXB || (v < 0 ? -v : v) < 8) begin
            m_vy = 0; nvx = 0; m_st = 2;
          end else m_vy = v;
          m_b = m_b < 15 ? m_b + 1 : 15;
        end else begin
          m_y = yc; m_vy = m_vy + 1;
        end
        m_vx = nvx;
      end
    end else if (rearm) m_st = 0;
    m_land = (m_st == 2 && prev != 2) ? 1 : 0;
    exp_q.push_back({12'(m_x), 12'(m_y), m_st == 1, m_land[0], 4'(m_b)});
  end
  // monitor: compare every presented output against the queued expectation
  always @(negedge clk) begin
    logic [29:0] e, g;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {xpos, ypos, busy, landed, bounces};
      vec++;
      if (g !== e) begin
        miss++;
        $display("FAIL out cyc=%0d got x=%0d y=%0d busy=%b land=%b b=%0d want x=%0d y=%0d busy=%b land=%b b=%0d",
                 cyc, g[29:18], g[17:6], g[5], g[4], g[3:0], e[29:18], e[17:6], e[5], e[4], e[3:0]);
      end
    end
  end
  task automatic spot(input string n, input int a, input int e);
    vec++;
    if (a != e) begin
      miss++;
      $display("FAIL %s: got %0d want %0d", n, a, e);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic fire(input int x, input int y, input int vx, input int vy);
    mouse_xpos = 12'(x); mouse_ypos = 12'(y); vx_init = 16'(vx); vy_init = 16'(vy);
    launch = 1'b1;
    step(1);
    launch = 1'b0;
  endtask
  initial begin
    int lands;
    step(3);
    spot("rst_x", xpos, 0);
    spot("rst_busy", busy, 0);
    rst = 1'b0;
    mouse_xpos = 300; mouse_ypos = 200;
    step(1);
    spot("idle_x", xpos, 300);
    spot("idle_y", ypos, 200);
    mouse_ypos = 700;
    step(1);
    spot("idle_clamp_y", ypos, 536);
    fire(100, 100, 16, 0);
    spot("launch_busy", busy, 1);
    spot("launch_x", xpos, 100);
    step(4);
    spot("tick1_x", xpos, 102);
    step(32);
    spot("tick9_y", ypos, 101);
    step(8);
    rst = 1'b1;
    step(1);
    spot("midrst_busy", busy, 0);
    spot("midrst_y", ypos, 0);
    spot("midrst_b", bounces, 0);
    rst = 1'b0;
    step(2);
    fire(740, 100, 64, 0);
    step(4);
    spot("wall_t1", xpos, 748);
    step(4);
    spot("wall_t2", xpos, 752);
    step(4);
    spot("wall_t3", xpos, 744);
    rst = 1'b1; step(1); rst = 1'b0; step(1);
    fire(400, 520, 0, 80);
    step(4);
    spot("floor_t1", ypos, 530);
    step(4);
    spot("floor_t2", ypos, 536);
    spot("floor_b", bounces, 1);
    rst = 1'b1; step(1); rst = 1'b0; step(1);
    fire(200, 0, 0, 0);
    lands = 0;
    for (int i = 0; i < 3000; i++) begin
      step(1);
      if (landed) begin lands++; launch = 1'b1; end
    end
    spot("rest_lands", lands, 1);
    spot("rest_b", bounces, 2);
    spot("rest_y", ypos, 536);
    spot("rest_x", xpos, 200);
    spot("rest_busy", busy, 0);
    launch = 1'b0; rearm = 1'b1; mouse_xpos = 10; mouse_ypos = 20;
    step(1);
    rearm = 1'b0;
    step(1);
    spot("rearm_y", ypos, 20);
    for (int k = 0; k < 14; k++) begin
      fire($urandom_range(0, 4095), $urandom_range(0, 700),
           int'($urandom_range(0, 600)) - 300, int'($urandom_range(0, 600)) - 300);
      for (int i = 0; i < 300; i++) begin
        launch = $urandom_range(0, 7) == 0;
        rearm = $urandom_range(0, 15) == 0;
        rst = $urandom_range(0, 599) == 0;
        if ($urandom_range(0, 3) == 0) begin
          mouse_xpos = 12'($urandom_range(0, 4095));
          mouse_ypos = 12'($urandom_range(0, 4095));
          vx_init = 16'(int'($urandom_range(0, 600)) - 300);
          vy_init = 16'(int'($urandom_range(0, 600)) - 300);
        end
        step(1);
      end
      rst = 1'b0; launch = 1'b0; rearm = 1'b1;
      step(1);
      rearm = 1'b0;
      step(1);
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
